seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//  Runtime-programmable serial pattern detector, successor to the fixed "1010" Mealy detector.
//  - Pattern of 1..MAX_LEN bits, loaded through a config port.
//  - Modes: overlap / non-overlap, Mealy (same-cycle) / Moore (registered) match pulse.
//  - Saturating match counter.
//  - Sits behind the tt_um_* top: din from ui_in[0], match/count routed to uo_out.
// PARAMETERS
//  MAX_LEN  8  longest pattern supported, in bits (>=2)
//  CNT_W    8  width of the match counter
//  LEN_W    $clog2(MAX_LEN+1)  width of cfg_len (localparam, not overridable)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        asynchronous active-low reset
//  en           in   1        din valid this cycle; no shift and no match when low
//  din          in   1        serial input bit
//  cfg_load     in   1        1-cycle strobe: capture cfg_* fields
//  cfg_pattern  in   MAX_LEN  pattern; bit[cfg_len-1] = first bit received, bit[0] = last
//  cfg_len      in   LEN_W    pattern length; legal range 1..MAX_LEN
//  cfg_overlap  in   1        1 = overlapping matches allowed
//  cfg_moore    in   1        1 = match registered (+1 cycle); 0 = combinational Mealy
//  cnt_clr      in   1        synchronous clear of match_cnt
//  match        out  1        1-cycle match pulse
//  match_cnt    out  CNT_W    matches since reset/clear, saturating
//  cfg_err      out  1        last cfg_load had an illegal length
//  armed        out  1        detector in RUN state
// BEHAVIOUR
//  Reset values
//  - state=UNCFG; history, fill, match_cnt, match_q, cfg_err = 0.
//  - Stored pattern=0, len=0, overlap=0, moore=0.
//  FSM: UNCFG -> RUN on legal cfg_load; RUN -> UNCFG on illegal cfg_load; RUN holds otherwise.
//  cfg_load
//  - Legal length (1..MAX_LEN): registers pattern/len/modes, cfg_err<=0.
//  - Illegal length (0 or >MAX_LEN): cfg_err<=1, state<=UNCFG.
//  - Either case: clears history and fill. match_cnt is kept.
//  - din is ignored in the load cycle.
//  In UNCFG: no shifting; match=0; armed=0.
//  In RUN, per cycle with en=1:
//  - cand = {hist[MAX_LEN-2:0], din}.
//  - hit = (fill >= len-1) && (cand[len-1:0] == pattern[len-1:0]).
//  - Normal update: hist <= cand; fill <= min(fill+1, MAX_LEN).
//  - hit with cfg_overlap=0: hist <= 0; fill <= 0 (next match needs len fresh bits).
//  - hit with cfg_overlap=1: normal shift.
//  en=0: hist and fill hold; hit=0.
//  match output
//  - Mealy: match = hit (combinational, same cycle as the last pattern bit).
//  - Moore: match = match_q, where match_q <= hit; pulse appears the next cycle.
//  - Mode change by cfg_load clears match_q.
//  match_cnt
//  - +1 per hit. Counts hits, so the count is mode-independent.
//  - Holds at 2^CNT_W-1.
//  - cnt_clr has priority: a hit in the same cycle is discarded and the count goes to 0.
//  len=1: every matching bit hits. Non-overlap re-arms immediately because fill=0 suffices.
//  Reset mid-stream: all history is lost and a reload is required (state=UNCFG).
// STRUCTURE
//  - Package seq_detect_pkg: state enum {UNCFG, RUN}; MAX_LEN_DEF and CNT_W_DEF defaults.
//  - Sub-module sat_counter #(CNT_W): inc, clr (clr priority), saturating.
//  - Pattern compare uses a len-derived mask:
//    hit = ((cand ^ pattern) & mask) == 0, with mask = (1<<len)-1 and fill qualification.
// TESTING
//  - len=4, pattern=1010, overlap=1, Mealy; din 1,0,1,0,1,0 ->
//    match high in the cycles of bits 4 and 6; cnt=2.
//  - Same stream, overlap=0 -> match only at bit 4; cnt=1.
//  - Moore mode, pattern 1010, stream 1,0,1,0 -> match high one cycle after bit 4, 1 cycle wide.
//  - cfg_len=0 then cfg_len=9 (MAX_LEN=8) -> cfg_err=1, armed=0, no match on any stream.
//    Reload len=3, pattern 111 -> cfg_err=0, armed=1.
//  - CNT_W=2, pattern 1 (len=1), din=1 for 5 cycles -> cnt 1,2,3,3,3.
//    cnt_clr on a hit cycle -> cnt=0.
//  - Reset mid-pattern after bits 1,0,1 -> armed=0, cnt=0.
//    Bits 0 after reload -> no match until 4 fresh bits are seen.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the programmable serial pattern detector.
package seq_detect_pkg;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter; clear wins over increment in the same cycle.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap/non-overlap and
// Mealy/Moore match pulse selection, plus a saturating match counter.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter  int MAX_LEN = MAX_LEN_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err,
  output logic               armed
);

  state_e             r_state;
  state_e             w_state_nxt;

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_moore;
  logic               r_cfg_err;

  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match_q;

  logic               w_cfg_legal;
  logic               w_run;
  logic               w_shift;
  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_filled;
  logic               w_hit;

  // Low 'len' bits set; computed one bit wider so len == MAX_LEN does not overflow.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN:0] m;
    m = ((MAX_LEN + 1)'(1) << len) - (MAX_LEN + 1)'(1);
    return m[MAX_LEN-1:0];
  endfunction

  assign w_cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_run       = (r_state == RUN);
  assign w_shift     = w_run && en && !cfg_load;

  assign w_cand   = {r_hist, din};
  assign w_mask   = len_mask(r_len);
  assign w_filled = (r_fill >= (r_len - LEN_W'(1)));
  assign w_hit    = w_shift && w_filled && (((w_cand ^ r_pattern) & w_mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= UNCFG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cfg_load) begin
      w_state_nxt = w_cfg_legal ? RUN : UNCFG;
    end
  end

  // Configuration capture; an illegal load leaves the old pattern in place but disarms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_moore   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (cfg_load) begin
      if (w_cfg_legal) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_moore   <= cfg_moore;
        r_cfg_err <= 1'b0;
      end else begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  // History shift; a non-overlapping hit flushes so the next match needs len fresh bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_match_q <= 1'b0;
    end else if (cfg_load) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_match_q <= 1'b0;
    end else begin
      r_match_q <= w_hit;
      if (w_shift) begin
        if (w_hit && !r_overlap) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_cand[MAX_LEN-2:0];
          r_fill <= (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hit),
    .clr   (cnt_clr),
    .cnt   (match_cnt)
  );

  assign match   = w_run && (r_moore ? r_match_q : w_hit);
  assign cfg_err = r_cfg_err;
  assign armed   = w_run;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog against a list-based reference model.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               din;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_moore;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;
  logic               armed;

  seq_detect_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .din         (din),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_moore   (cfg_moore),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             match;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: received bits since the last flush, oldest first.
  bit               m_armed, m_err, m_ov, m_moore, m_mq;
  int               m_len;
  bit [MAX_LEN-1:0] m_pat;
  int               m_cnt;
  bit               hist_q[$];

  function automatic bit model_hit(input bit d);
    bit b;
    if (hist_q.size() + 1 < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      b = (j == 0) ? d : hist_q[hist_q.size() - j];
      if (b != m_pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_err = 0; m_ov = 0; m_moore = 0; m_mq = 0;
    m_len = 0; m_pat = '0; m_cnt = 0;
    hist_q.delete();
  endtask

  task automatic drive(input bit e, input bit d, input bit ld, input bit [MAX_LEN-1:0] pat,
                       input int len, input bit ov, input bit mo, input bit clr);
    exp_t x;
    bit   hit;
    @(posedge clk);
    #1;
    rst_n = 1'b1; en = e; din = d; cfg_load = ld; cfg_pattern = pat;
    cfg_len = LEN_W'(len); cfg_overlap = ov; cfg_moore = mo; cnt_clr = clr;
    hit = (!ld && m_armed && e) ? model_hit(d) : 1'b0;
    x.match = m_armed && (m_moore ? m_mq : hit);
    x.cnt   = CNT_W'(m_cnt);
    x.armed = m_armed;
    x.err   = m_err;
    sb.push_back(x);
    if (ld) begin
      if (len >= 1 && len <= MAX_LEN) begin
        m_pat = pat; m_len = len; m_ov = ov; m_moore = mo; m_armed = 1; m_err = 0;
      end else begin
        m_err = 1; m_armed = 0;
      end
      hist_q.delete();
      m_mq = 0;
    end else begin
      m_mq = hit;
      if (m_armed && e) begin
        if (hit && !m_ov) hist_q.delete();
        else begin
          hist_q.push_back(d);
          if (hist_q.size() > MAX_LEN) void'(hist_q.pop_front());
        end
      end
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic do_reset();
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = 1'b0; en = 0; din = 0; cfg_load = 0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 0; cfg_moore = 0; cnt_clr = 0;
    model_reset();
    x.match = 0; x.cnt = '0; x.armed = 0; x.err = 0;
    sb.push_back(x);
  endtask

  task automatic load(input bit [MAX_LEN-1:0] pat, input int len, input bit ov,
                      input bit mo, input bit clr);
    drive(1'b0, 1'b0, 1'b1, pat, len, ov, mo, clr);
  endtask

  task automatic bitin(input bit d);
    drive(1'b1, d, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_cnt(input string name, input int v);
    @(negedge clk);
    checks++;
    if (match_cnt !== CNT_W'(v)) begin
      errors++;
      $display("FAIL %s: match_cnt got %0d expected %0d", name, match_cnt, v);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_x = sb.pop_front();
      checks++;
      if (match !== mon_x.match) begin
        errors++;
        $display("FAIL match @%0t: got %b expected %b", $time, match, mon_x.match);
      end
      checks++;
      if (match_cnt !== mon_x.cnt) begin
        errors++;
        $display("FAIL match_cnt @%0t: got %0d expected %0d", $time, match_cnt, mon_x.cnt);
      end
      checks++;
      if (armed !== mon_x.armed) begin
        errors++;
        $display("FAIL armed @%0t: got %b expected %b", $time, armed, mon_x.armed);
      end
      checks++;
      if (cfg_err !== mon_x.err) begin
        errors++;
        $display("FAIL cfg_err @%0t: got %b expected %b", $time, cfg_err, mon_x.err);
      end
    end
  end

  initial begin
    bit [MAX_LEN-1:0] pat;
    int               len;
    int               k;
    bit               d;
    rst_n = 1'b0; en = 0; din = 0; cfg_load = 0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 0; cfg_moore = 0; cnt_clr = 0;
    model_reset();
    do_reset();

    // 1010 overlapping, Mealy
    load(8'b1010, 4, 1, 0, 1);
    for (int i = 0; i < 6; i++) bitin(i % 2 == 0);
    idle();
    expect_cnt("overlap_1010", 2);

    // 1010 non-overlapping
    load(8'b1010, 4, 0, 0, 1);
    for (int i = 0; i < 6; i++) bitin(i % 2 == 0);
    idle();
    expect_cnt("nonoverlap_1010", 1);

    // Moore
    load(8'b1010, 4, 1, 1, 1);
    for (int i = 0; i < 4; i++) bitin(i % 2 == 0);
    idle(); idle();
    expect_cnt("moore_1010", 1);

    // Illegal lengths then a legal reload
    load(8'b0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) bitin(1'b1);
    load(8'hFF, 9, 1, 0, 0);
    for (int i = 0; i < 8; i++) bitin(i % 2 == 0);
    load(8'b111, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) bitin(1'b1);

    // len=1 saturation and clear priority
    load(8'b1, 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) bitin(1'b1);
    idle();
    expect_cnt("saturate", CNT_MAX);
    drive(1, 1, 0, '0, 0, 0, 0, 1);
    idle();
    expect_cnt("clr_on_hit", 0);

    // Reset mid-pattern, reload, fresh bits required
    load(8'b1010, 4, 1, 0, 0);
    bitin(1); bitin(0); bitin(1);
    do_reset();
    load(8'b1010, 4, 1, 0, 0);
    bitin(0); bitin(1); bitin(0);
    bitin(1); bitin(0); bitin(1); bitin(0);

    // Randomized configurations and streams
    for (int r = 0; r < 40; r++) begin
      if ($urandom % 8 == 0) do_reset();
      len = ($urandom % 10 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 5));
      pat = MAX_LEN'($urandom);
      load(pat, len, 1'($urandom), 1'($urandom), ($urandom % 4 == 0));
      k = len - 1;
      for (int c = 0; c < 50; c++) begin
        if (len >= 1 && len <= MAX_LEN && ($urandom % 2 == 0)) begin
          d = pat[k];
          k = (k == 0) ? len - 1 : k - 1;
        end else begin
          d = 1'($urandom);
        end
        if ($urandom % 60 == 0)
          drive(1'($urandom), d, 1, MAX_LEN'($urandom), int'($urandom_range(0, 9)),
                1'($urandom), 1'($urandom), 1'b0);
        else
          drive(($urandom % 8 != 0), d, 0, '0, 0, 0, 0, ($urandom % 40 == 0));
      end
    end
    idle(); idle();

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
